// File: rtl/rpspmc_ctrl_pkg.sv
// Shared controller definitions: servo mode encoding, mode-bit indices used with
// controller_configuration, and the generic saturating clamp.
package rpspmc_ctrl_pkg;

    typedef enum logic [1:0] {
        DISABLED,
        RUN,
        HOLD
    } ctrl_mode_e;

    localparam int unsigned MODE_BITS_W = 4;
    localparam int unsigned MODE_EN     = 0;
    localparam int unsigned MODE_HOLD   = 1;
    localparam int unsigned MODE_UW     = 2;
    localparam int unsigned MODE_TH     = 3;

    // Wide enough for any sum/product width the servo is configured with.
    localparam int CLAMP_W = 128;

    // Upper bound is applied first, so lo wins when lo > hi.
    function automatic logic signed [CLAMP_W-1:0] sat_clamp(
        input logic signed [CLAMP_W-1:0] value,
        input logic signed [CLAMP_W-1:0] lo,
        input logic signed [CLAMP_W-1:0] hi
    );
        logic signed [CLAMP_W-1:0] r;
        r = (value > hi) ? hi : value;
        r = (r < lo) ? lo : r;
        return r;
    endfunction

endpackage

// File: rtl/pi_sat_clamp.sv
// Combinational saturate of a wide signed value into [lo, hi] with hit flags.
module pi_sat_clamp
    import rpspmc_ctrl_pkg::*;
#(
    parameter int W_IN  = 34,
    parameter int W_OUT = 32
) (
    input  logic signed [W_IN-1:0]  value,
    input  logic signed [W_OUT-1:0] lo,
    input  logic signed [W_OUT-1:0] hi,
    output logic signed [W_OUT-1:0] result,
    output logic                    hit_hi,
    output logic                    hit_lo
);

    logic signed [CLAMP_W-1:0] v_ext;
    logic signed [CLAMP_W-1:0] lo_ext;
    logic signed [CLAMP_W-1:0] hi_ext;
    logic signed [CLAMP_W-1:0] r_ext;

    always_comb begin
        v_ext  = CLAMP_W'(value);
        lo_ext = CLAMP_W'(lo);
        hi_ext = CLAMP_W'(hi);
        r_ext  = sat_clamp(v_ext, lo_ext, hi_ext);
        result = W_OUT'(r_ext);
        hit_hi = (r_ext == hi_ext) && (v_ext >= hi_ext);
        hit_lo = (r_ext == lo_ext) && (v_ext <= lo_ext);
    end

endmodule

// File: rtl/controller_pi_servo.sv
// Pipelined PI servo: error/deadband, gain products, integrator, clamped output (4-cycle latency).
// Defining CONTROLLER_PI_MONITOR_EN adds the mon_error / mon_integrator debug ports.
module controller_pi_servo
    import rpspmc_ctrl_pkg::*;
#(
    parameter int width_in        = 32,
    parameter int width_setpoint  = 32,
    parameter int width_consts    = 32,
    parameter int width_limits    = 32,
    parameter int width_threshold = 32,
    parameter int q_shift         = 31
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic signed [width_in-1:0]       S_AXIS_in_tdata,
    input  logic                             S_AXIS_in_tvalid,
    input  logic signed [width_setpoint-1:0] S_AXIS_setpoint_tdata,
    input  logic                             S_AXIS_setpoint_tvalid,
    input  logic signed [width_consts-1:0]   cp,
    input  logic signed [width_consts-1:0]   ci,
    input  logic signed [width_limits-1:0]   upper,
    input  logic signed [width_limits-1:0]   lower,
    input  logic [width_threshold-1:0]       S_AXIS_threshold_tdata,
    input  logic signed [width_limits-1:0]   S_AXIS_reset_tdata,
    input  logic                             controller_enable,
    input  logic                             controller_hold,
    input  logic                             controller_option_uw,
    input  logic                             controller_option_th,
    output logic signed [width_limits-1:0]   M_AXIS_control_tdata,
    output logic                             M_AXIS_control_tvalid,
    output logic [1:0]                       saturated
`ifdef CONTROLLER_PI_MONITOR_EN
    ,
    output logic signed [width_setpoint:0]   mon_error,
    output logic signed [width_limits-1:0]   mon_integrator
`endif
);

    localparam int EW = width_setpoint + 1;
    localparam int PW = width_consts + EW;
    localparam int SW = PW + 1;

    logic unused_inputs;
    assign unused_inputs = S_AXIS_setpoint_tvalid;

    logic [MODE_BITS_W-1:0] mode_bits;
    assign mode_bits[MODE_EN]   = controller_enable;
    assign mode_bits[MODE_HOLD] = controller_hold;
    assign mode_bits[MODE_UW]   = controller_option_uw;
    assign mode_bits[MODE_TH]   = controller_option_th;

    // S0: error and deadband
    logic signed [EW-1:0] err_raw, err_db, e0;
    logic [EW-1:0]        err_mag;
    logic                 v0;

    always_comb begin
        err_raw = EW'(S_AXIS_setpoint_tdata) - EW'(S_AXIS_in_tdata);
        err_mag = err_raw[EW-1] ? -err_raw : err_raw;
        err_db  = err_raw;
        if (mode_bits[MODE_TH] && (err_mag < EW'(S_AXIS_threshold_tdata)))
            err_db = '0;
    end

    // S1: gain products
    logic signed [PW-1:0] p1, di1;
    logic                 v1;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            v0  <= 1'b0;
            e0  <= '0;
            v1  <= 1'b0;
            p1  <= '0;
            di1 <= '0;
        end else begin
            v0 <= S_AXIS_in_tvalid;
            if (S_AXIS_in_tvalid)
                e0 <= err_db;
            v1 <= v0;
            if (v0) begin
                p1  <= PW'(cp) * PW'(e0);
                di1 <= PW'(ci) * PW'(e0);
            end
        end
    end

    // S2: scaling, mode FSM and integrator
    ctrl_mode_e                   mode_q, mode_d;
    logic signed [width_limits-1:0] integ, integ_d, integ_next;
    logic signed [PW-1:0]         p_sh, di_sh, p2, p2_d;
    logic signed [SW-1:0]         integ_sum;
    logic                         windup_block;
    logic                         v2;
    logic                         int_hit_hi_unused, int_hit_lo_unused;

    always_comb begin
        p_sh      = p1 >>> q_shift;
        di_sh     = di1 >>> q_shift;
        integ_sum = SW'(integ) + SW'(di_sh);
    end

    pi_sat_clamp #(
        .W_IN (SW),
        .W_OUT(width_limits)
    ) u_integ_clamp (
        .value (integ_sum),
        .lo    (lower),
        .hi    (upper),
        .result(integ_next),
        .hit_hi(int_hit_hi_unused),
        .hit_lo(int_hit_lo_unused)
    );

    always_comb begin
        mode_d       = mode_q;
        integ_d      = integ;
        p2_d         = p2;
        windup_block = mode_bits[MODE_UW] &&
                       (((M_AXIS_control_tdata == upper) && !di_sh[PW-1] && (di_sh != '0)) ||
                        ((M_AXIS_control_tdata == lower) && di_sh[PW-1]));
        if (v1) begin
            if (!mode_bits[MODE_EN])
                mode_d = DISABLED;
            else if (mode_bits[MODE_HOLD])
                mode_d = HOLD;
            else
                mode_d = RUN;
            case (mode_d)
                // Zeroing p makes the output stage produce clamp(reset value).
                DISABLED: begin
                    integ_d = S_AXIS_reset_tdata;
                    p2_d    = '0;
                end
                RUN: begin
                    p2_d = p_sh;
                    if (!windup_block)
                        integ_d = integ_next;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            v2     <= 1'b0;
            mode_q <= DISABLED;
            integ  <= '0;
            p2     <= '0;
        end else begin
            v2     <= v1;
            mode_q <= mode_d;
            integ  <= integ_d;
            p2     <= p2_d;
        end
    end

    // S3: sum and output clamp
    logic signed [SW-1:0]           sum;
    logic signed [width_limits-1:0] out_next;
    logic                           hit_hi, hit_lo;

    assign sum = SW'(p2) + SW'(integ);

    pi_sat_clamp #(
        .W_IN (SW),
        .W_OUT(width_limits)
    ) u_out_clamp (
        .value (sum),
        .lo    (lower),
        .hi    (upper),
        .result(out_next),
        .hit_hi(hit_hi),
        .hit_lo(hit_lo)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            M_AXIS_control_tvalid <= 1'b0;
            M_AXIS_control_tdata  <= '0;
            saturated             <= '0;
        end else begin
            M_AXIS_control_tvalid <= v2;
            if (v2 && (mode_q != HOLD)) begin
                M_AXIS_control_tdata <= out_next;
                saturated            <= {hit_hi, hit_lo};
            end
        end
    end

`ifdef CONTROLLER_PI_MONITOR_EN
    logic signed [EW-1:0] e1, e2;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            e1             <= '0;
            e2             <= '0;
            mon_error      <= '0;
            mon_integrator <= '0;
        end else begin
            if (v0)
                e1 <= e0;
            if (v1)
                e2 <= e1;
            if (v2) begin
                mon_error      <= e2;
                mon_integrator <= integ;
            end
        end
    end
`endif

endmodule

// File: tb/tb_controller_pi_servo.sv
// Self-checking bench for controller_pi_servo: directed vector table plus multi-cycle sequences.
module tb_controller_pi_servo;

    localparam logic signed [31:0] C05  = 32'sh4000_0000;
    localparam logic signed [31:0] CI   = 32'sh0100_0000;
    localparam logic signed [31:0] GMAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] LMIN = 32'sh8000_0000;
    localparam int                 M    = 1000000;
    localparam int                 NV   = 21;

    typedef struct {
        logic signed [31:0] sp, x, cp, ci, up, lo;
        logic [31:0]        thr;
        logic signed [31:0] rv;
        logic               en, hold, uw, th;
        logic signed [31:0] exp_out;
        logic [1:0]         exp_sat;
    } vec_t;

    logic               aclk = 1'b0;
    logic               areset = 1'b0;
    logic signed [31:0] in_tdata = '0;
    logic               in_tvalid = 1'b0;
    logic signed [31:0] sp_tdata = '0;
    logic               sp_tvalid = 1'b0;
    logic signed [31:0] cp = '0, ci = '0, upper = '0, lower = '0;
    logic [31:0]        thr_tdata = '0;
    logic signed [31:0] rst_tdata = '0;
    logic               en = 1'b0, hold = 1'b0, uw = 1'b0, th = 1'b0;
    logic signed [31:0] out_tdata;
    logic               out_tvalid;
    logic [1:0]         saturated;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs [NV];

    controller_pi_servo dut (
        .aclk                  (aclk),
        .areset                (areset),
        .S_AXIS_in_tdata       (in_tdata),
        .S_AXIS_in_tvalid      (in_tvalid),
        .S_AXIS_setpoint_tdata (sp_tdata),
        .S_AXIS_setpoint_tvalid(sp_tvalid),
        .cp                    (cp),
        .ci                    (ci),
        .upper                 (upper),
        .lower                 (lower),
        .S_AXIS_threshold_tdata(thr_tdata),
        .S_AXIS_reset_tdata    (rst_tdata),
        .controller_enable     (en),
        .controller_hold       (hold),
        .controller_option_uw  (uw),
        .controller_option_th  (th),
        .M_AXIS_control_tdata  (out_tdata),
        .M_AXIS_control_tvalid (out_tvalid),
        .saturated             (saturated)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        in_tvalid = 1'b0;
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        tick();
    endtask

    function automatic vec_t mk(
        input logic signed [31:0] sp, x, cpv, civ, up, lo,
        input logic [31:0] thr,
        input logic signed [31:0] rv,
        input logic e, h, u, t,
        input logic signed [31:0] eo,
        input logic [1:0] es
    );
        vec_t v;
        v.sp = sp; v.x = x; v.cp = cpv; v.ci = civ; v.up = up; v.lo = lo;
        v.thr = thr; v.rv = rv; v.en = e; v.hold = h; v.uw = u; v.th = t;
        v.exp_out = eo; v.exp_sat = es;
        return v;
    endfunction

    task automatic set_cfg(input vec_t v);
        sp_tdata = v.sp; in_tdata = v.x; cp = v.cp; ci = v.ci;
        upper = v.up; lower = v.lo; thr_tdata = v.thr; rst_tdata = v.rv;
        en = v.en; hold = v.hold; uw = v.uw; th = v.th;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!out_tvalid && k < 12) begin
            tick();
            k++;
        end
        check({name, "_tvalid"}, out_tvalid, 1);
    endtask

    task automatic send_beat(input string name);
        in_tvalid = 1'b1;
        tick();
        in_tvalid = 1'b0;
        wait_valid(name);
    endtask

    task automatic run_uw(input logic u, input logic signed [31:0] exp_i);
        do_reset();
        set_cfg(mk(1000, 0, C05, CI, 100, -M, 0, 0, 1, 0, u, 0, 0, 2'b00));
        for (int k = 0; k < 16; k++) begin
            send_beat($sformatf("uw%0d_b%0d", u, k));
            tick();
        end
        check($sformatf("uw%0d_pinned_out", u), out_tdata, 100);
        check($sformatf("uw%0d_pinned_sat", u), saturated, 2'b10);
        set_cfg(mk(1000, 1000, 0, CI, 100, -M, 0, 0, 1, 0, u, 0, 0, 2'b00));
        send_beat($sformatf("uw%0d_probe", u));
        check($sformatf("uw%0d_integrator", u), out_tdata, exp_i);
        tick();
    endtask

    initial begin
        bit seen;

        vecs[0]  = mk(1000, 0,    C05, 0,   M,    -M,    0,  0,    1, 0, 0, 0, 500,   2'b00);
        vecs[1]  = mk(0,    1000, C05, 0,   M,    -M,    0,  0,    1, 0, 0, 0, -500,  2'b00);
        vecs[2]  = mk(1000, 0,    0,   CI,  M,    -M,    0,  0,    1, 0, 0, 0, 7,     2'b00);
        vecs[3]  = mk(1000, 0,    0,   CI,  M,    -M,    0,  0,    1, 0, 0, 0, 14,    2'b00);
        vecs[4]  = mk(0,    1000, 0,   CI,  M,    -M,    0,  0,    1, 0, 0, 0, 6,     2'b00);
        vecs[5]  = mk(49,   0,    0,   C05, M,    -M,    50, 0,    1, 0, 0, 1, 6,     2'b00);
        vecs[6]  = mk(50,   0,    0,   C05, M,    -M,    50, 0,    1, 0, 0, 1, 31,    2'b00);
        vecs[7]  = mk(0,    50,   0,   C05, M,    -M,    50, 0,    1, 0, 0, 1, 6,     2'b00);
        vecs[8]  = mk(49,   0,    0,   C05, M,    -M,    50, 0,    1, 0, 0, 0, 30,    2'b00);
        vecs[9]  = mk(0,    49,   0,   C05, M,    -M,    50, 0,    1, 0, 0, 1, 30,    2'b00);
        vecs[10] = mk(0,    0,    0,   0,   5,    10,    0,  0,    1, 0, 0, 0, 10,    2'b01);
        vecs[11] = mk(2000, 0,    C05, 0,   M,    -M,    0,  0,    1, 0, 0, 0, 1010,  2'b00);
        vecs[12] = mk(2000, 0,    C05, 0,   1000, -M,    0,  0,    1, 0, 0, 0, 1000,  2'b10);
        vecs[13] = mk(0,    4000, C05, 0,   M,    -1500, 0,  0,    1, 0, 0, 0, -1500, 2'b01);
        vecs[14] = mk(1000, 0,    C05, CI,  M,    -M,    0,  -300, 0, 0, 0, 0, -300,  2'b00);
        vecs[15] = mk(0,    0,    C05, CI,  M,    -M,    0,  -300, 1, 0, 0, 0, -300,  2'b00);
        vecs[16] = mk(1000, 0,    C05, CI,  M,    -M,    0,  -300, 1, 1, 0, 0, -300,  2'b00);
        vecs[17] = mk(1000, 0,    C05, CI,  M,    -M,    0,  200,  0, 1, 0, 0, 200,   2'b00);
        vecs[18] = mk(0,    0,    C05, CI,  M,    -M,    0,  200,  1, 0, 0, 0, 200,   2'b00);
        vecs[19] = mk(GMAX, LMIN, GMAX, GMAX, GMAX, LMIN, 0, 0,    1, 0, 0, 0, GMAX,  2'b10);
        vecs[20] = mk(LMIN, GMAX, GMAX, GMAX, GMAX, LMIN, 0, 0,    1, 0, 0, 0, LMIN,  2'b01);

        do_reset();
        check("reset_tvalid", out_tvalid, 0);
        check("reset_out", out_tdata, 0);
        check("reset_sat", saturated, 2'b00);

        // Single beat: exactly four cycles to the output strobe.
        set_cfg(mk(1000, 0, C05, 0, M, -M, 0, 0, 1, 0, 0, 0, 0, 2'b00));
        in_tvalid = 1'b1;
        tick();
        in_tvalid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("lat_tvalid_c%0d", c), out_tvalid, (c == 4) ? 1 : 0);
            if (c == 4)
                check("lat_out", out_tdata, 500);
            tick();
        end

        // Back-to-back beats: one result per cycle, integrator steps by 7.
        do_reset();
        set_cfg(mk(1000, 0, 0, CI, M, -M, 0, 0, 1, 0, 0, 0, 0, 2'b00));
        for (int c = 0; c < 15; c++) begin
            int j;
            in_tvalid = (c < 10);
            tick();
            j = c - 3;
            if (j >= 0 && j < 10) begin
                check($sformatf("b2b_tvalid_%0d", j), out_tvalid, 1);
                check($sformatf("b2b_out_%0d", j), out_tdata, 7 * (j + 1));
            end else begin
                check($sformatf("b2b_idle_c%0d", c), out_tvalid, 0);
            end
        end
        in_tvalid = 1'b0;

        run_uw(1'b1, 7);
        run_uw(1'b0, 100);

        do_reset();
        for (int i = 0; i < NV; i++) begin
            set_cfg(vecs[i]);
            send_beat($sformatf("vec%0d", i));
            check($sformatf("vec%0d_out", i), out_tdata, vecs[i].exp_out);
            check($sformatf("vec%0d_sat", i), saturated, vecs[i].exp_sat);
            tick();
        end

        // Reset with three beats in flight: none of them may emerge.
        set_cfg(mk(1000, 0, C05, 0, M, -M, 0, 0, 1, 0, 0, 0, 0, 2'b00));
        for (int k = 0; k < 3; k++) begin
            in_tvalid = 1'b1;
            tick();
        end
        in_tvalid = 1'b0;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_tvalid)
                seen = 1'b1;
        end
        check("flight_rst_tvalid", seen, 0);
        check("flight_rst_out", out_tdata, 0);
        check("flight_rst_sat", saturated, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
